// File: rtl/bus_ctrl.sv
// Load/store bus controller: byte/halfword/word access, read-modify-write for sub-word stores.
// Optional bus wait abort enabled by defining BUS_TIMEOUT_EN (limit set by TIMEOUT).
//   state | meaning
//   IDLE  | waiting for req
//   RD    | read request on bus (load or RMW fetch)
//   WR    | write request on bus
//   FIN   | transaction complete, result registered next edge
//   ERR   | misaligned/illegal/timeout, fault registered next edge
module bus_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  output logic        bus_rreq,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rdy
);

  typedef enum logic [2:0] {IDLE, RD, WR, FIN, ERR} state_t;

  state_t      state_q, state_d;
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rword_q;
  logic [31:0] merged, ld_ext;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        bad, tmo_hit;

  assign bad = (req_size == 2'b11) ||
               (req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00);

`ifdef BUS_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == 32'(TIMEOUT - 1));

  // Any state change restarts the count, so each bus phase gets a full budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tmo_cnt <= '0;
    else if (state_d != state_q)
      tmo_cnt <= '0;
    else if ((state_q == RD || state_q == WR) && !bus_rdy)
      tmo_cnt <= tmo_cnt + 32'd1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req) begin
        if (bad)                             state_d = ERR;
        else if (!req_we || req_size != 2'b10) state_d = RD;
        else                                 state_d = WR;
      end
      RD: if (bus_rdy)      state_d = we_q ? WR : FIN;
          else if (tmo_hit) state_d = ERR;
      WR: if (bus_rdy)      state_d = FIN;
          else if (tmo_hit) state_d = ERR;
      FIN:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rword_q <= '0;
    end else begin
      if (state_q == IDLE && req) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == RD && bus_rdy)
        rword_q <= bus_rdata;
    end
  end

  assign lane_b = rword_q[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h = rword_q[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    merged = rword_q;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    ld_ext = rword_q;
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   ld_ext = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: ld_ext = rword_q;
    endcase
    if (we_q) ld_ext = '0;
  end

  // Completion outputs are registered one edge after FIN/ERR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done  <= 1'b0;
      fault <= 1'b0;
      rdata <= '0;
    end else begin
      done  <= (state_q == FIN) || (state_q == ERR);
      fault <= (state_q == ERR);
      if (state_q == FIN)      rdata <= ld_ext;
      else if (state_q == ERR) rdata <= '0;
    end
  end

  assign busy      = (state_q != IDLE);
  assign bus_rreq  = (state_q == RD);
  assign bus_we    = (state_q == WR);
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_wdata = merged;

endmodule

// File: doc/bus_ctrl.md
BUS_CTRL -- requirements
Module: bus_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: bus wait cycles before abort (used only with BUS_TIMEOUT_EN).
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 REQ  input  1  CPU request strobe, sampled in IDLE only.
REQ-005 REQ_WE  input  1  1=store, 0=load.
REQ-006 REQ_ADDR  input  32  byte address.
REQ-007 REQ_WDATA  input  32  store data, right-aligned.
REQ-008 REQ_SIZE  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 REQ_UNSIGNED  input  1  1=zero-extend load, 0=sign-extend.
REQ-010 BUSY  output  1  transaction in progress.
REQ-011 DONE  output  1  one-cycle completion pulse.
REQ-012 FAULT  output  1  valid with DONE: misaligned/illegal or timeout.
REQ-013 RDATA  output  32  extended load result, valid with DONE.
REQ-014 BUS_ADDR  output  32  word-aligned address to IO/memory stage.
REQ-015 BUS_WDATA  output  32  write word to IO/memory stage.
REQ-016 BUS_WE  output  1  write request, held until BUS_RDY.
REQ-017 BUS_RREQ  output  1  read request, held until BUS_RDY.
REQ-018 BUS_RDATA  input  32  read word from IO/memory stage.
REQ-019 BUS_RDY  input  1  completes current bus request when sampled high.

Function
REQ-020 States SHALL be IDLE, RD, WR, FIN, ERR.
REQ-021 IDLE with REQ=1: latch all REQ_* fields; illegal size or misalignment (half addr[0]=1, word addr[1:0]!=0) -> ERR; load or sub-word store -> RD; word store -> WR.
REQ-022 RD: BUS_RREQ=1, BUS_ADDR={addr[31:2],2'b00}; on BUS_RDY capture BUS_RDATA; load -> FIN, sub-word store -> WR.
REQ-023 WR: BUS_WE=1; BUS_WDATA = store word, or captured read word with addressed byte/halfword lane replaced (read-modify-write); on BUS_RDY -> FIN.
REQ-024 FIN: DONE=1, FAULT=0, RDATA = selected lane extended per REQ_UNSIGNED (word: unchanged; stores: 0); -> IDLE.
REQ-025 ERR: DONE=1, FAULT=1, RDATA=0, no bus request issued; -> IDLE.
REQ-026 BUSY=1 in every state except IDLE; BUSY=0 in IDLE.
REQ-027 BUS_RREQ and BUS_WE SHALL never be high in the same cycle; BUS_ADDR/BUS_WDATA stable while either is high.
REQ-028 BUS_RDY sampled high in the first request cycle is accepted; minimum latencies from accept edge T: load DONE at T+2, word store T+2, sub-word store T+3.
REQ-029 BUS_RDY while neither request active SHALL be ignored.
REQ-030 REQ during non-IDLE states SHALL be ignored; back-to-back requests earliest one cycle after DONE.
REQ-031 Lane select: byte lane addr[1:0], halfword lane addr[1]; little-endian.

Reset
REQ-032 RST SHALL force IDLE immediately, including mid-transaction, abandoning any bus request.
REQ-033 Reset values: BUSY, DONE, FAULT, BUS_WE, BUS_RREQ = 0; RDATA, BUS_ADDR, BUS_WDATA = 0; timeout counter = 0.

Configuration
REQ-034 Macro BUS_TIMEOUT_EN defined: counter clears on entering RD/WR, increments each cycle without BUS_RDY; reaching TIMEOUT drops request and goes to ERR (DONE=1, FAULT=1).
REQ-035 BUS_TIMEOUT_EN undefined: no counter; RD/WR wait indefinitely for BUS_RDY.

Verification
REQ-036 Load word addr 0x10, BUS_RDATA=0xDEADBEEF, RDY at first RREQ cycle -> DONE at T+2, RDATA=0xDEADBEEF, FAULT=0.
REQ-037 Signed byte load addr 0x13, BUS_RDATA=0x80112233 -> RDATA=0xFFFFFF80; REQ_UNSIGNED=1 -> 0x00000080.
REQ-038 Byte store 0xAB to 0x21, read word 0x11223344 -> one RREQ then one WE, BUS_ADDR=0x20, BUS_WDATA=0x1122AB44.
REQ-039 Word load addr 0x06 -> DONE=1, FAULT=1 one cycle after accept, BUS_RREQ/BUS_WE never asserted.
REQ-040 BUS_TIMEOUT_EN, TIMEOUT=4, RDY held 0 on load -> RREQ dropped after 4 wait cycles, DONE=1 FAULT=1.
REQ-041 RST pulsed while in WR with RDY=0 -> BUS_WE=0, BUSY=0 without clock edge; next REQ serviced normally.
